// File: rtl/skeleton_ta_top.sv
// Five-stage (F/D/X/M/W) pipelined processor with register file, instruction ROM and data RAM.
// All memory and register-file buses are brought out for observation.
module skeleton_ta_top #(
  parameter string IMEM_FILE = "imem.mif",
  parameter int    MEM_DEPTH = 4096
) (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] address_imem,
  output logic [31:0] q_imem,
  output logic [11:0] address_dmem,
  output logic [31:0] d_dmem,
  output logic        wren_dmem,
  output logic [31:0] q_dmem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  // ---------------------------------------------------------------- memories
  logic [31:0] imem_rom [MEM_DEPTH];
  logic [31:0] dmem_ram [MEM_DEPTH];
  logic [31:0] q_imem_reg;
  logic [31:0] q_dmem_reg;
  logic        stall;

  // The ROM output register doubles as the F/D latch, so it holds on a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_imem_reg <= '0;
    end else if (!stall) begin
      q_imem_reg <= imem_rom[address_imem];
    end
  end

  always_ff @(posedge clock) begin
    if (wren_dmem) begin
      dmem_ram[address_dmem] <= d_dmem;
    end
    q_dmem_reg <= dmem_ram[address_dmem];
  end

  assign q_imem = q_imem_reg;
  assign q_dmem = q_dmem_reg;

  // ---------------------------------------------------------------- register file
  logic [31:0] rf_regs [32];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_regs[i] <= '0;
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      rf_regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Write-through so a D-stage read sees the value being written this cycle.
  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 :
                         (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegA) ? data_writeReg :
                         rf_regs[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 :
                         (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegB) ? data_writeReg :
                         rf_regs[ctrl_readRegB];

  // ---------------------------------------------------------------- fetch
  logic [11:0] pc_reg;
  logic [11:0] pc_next;

  assign pc_next      = stall ? pc_reg : pc_reg + 12'd1;
  assign address_imem = pc_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_reg <= '0;
    else        pc_reg <= pc_next;
  end

  // ---------------------------------------------------------------- decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic       fd_uses_a, fd_uses_b;

  assign fd_op = q_imem_reg[31:27];
  assign fd_rd = q_imem_reg[26:22];
  assign fd_rs = q_imem_reg[21:17];
  assign fd_rt = q_imem_reg[16:12];

  assign ctrl_readRegA = fd_rs;
  assign ctrl_readRegB = (fd_op == OP_SW) ? fd_rd : fd_rt;
  assign fd_uses_a = (fd_op == OP_R) || (fd_op == OP_ADDI) || (fd_op == OP_SW) || (fd_op == OP_LW);
  assign fd_uses_b = (fd_op == OP_R) || (fd_op == OP_SW);

  logic [31:0] dx_insn_reg, dx_a_reg, dx_b_reg;
  logic [4:0]  x_op, x_rd, x_rs, x_rt, x_shamt, x_aluop, x_srcb;

  assign x_op    = dx_insn_reg[31:27];
  assign x_rd    = dx_insn_reg[26:22];
  assign x_rs    = dx_insn_reg[21:17];
  assign x_rt    = dx_insn_reg[16:12];
  assign x_shamt = dx_insn_reg[11:7];
  assign x_aluop = dx_insn_reg[6:2];
  assign x_srcb  = (x_op == OP_SW) ? x_rd : x_rt;

  assign stall = (x_op == OP_LW) && (x_rd != 5'd0) &&
                 ((fd_uses_a && fd_rs == x_rd) || (fd_uses_b && ctrl_readRegB == x_rd));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset || stall) begin
      dx_insn_reg <= '0;
      dx_a_reg    <= '0;
      dx_b_reg    <= '0;
    end else begin
      dx_insn_reg <= q_imem_reg;
      dx_a_reg    <= data_readRegA;
      dx_b_reg    <= data_readRegB;
    end
  end

  // ---------------------------------------------------------------- execute
  logic        xm_we_reg, xm_sw_reg, xm_lw_reg;
  logic [4:0]  xm_wreg_reg, xm_rd_reg;
  logic [31:0] xm_val_reg, xm_b_reg;
  logic        mw_we_reg, mw_lw_reg;
  logic [4:0]  mw_wreg_reg;
  logic [31:0] mw_val_reg;

  logic [31:0] x_a, x_b, x_imm, x_sum, x_diff, x_addr, x_result, x_code;
  logic        x_we, x_ovf;
  logic [4:0]  x_wreg;

  // MX has priority over WX; neither forwards a write to r0.
  assign x_a = (xm_we_reg && xm_wreg_reg != 5'd0 && xm_wreg_reg == x_rs) ? xm_val_reg :
               (mw_we_reg && mw_wreg_reg != 5'd0 && mw_wreg_reg == x_rs) ? data_writeReg :
               dx_a_reg;
  assign x_b = (xm_we_reg && xm_wreg_reg != 5'd0 && xm_wreg_reg == x_srcb) ? xm_val_reg :
               (mw_we_reg && mw_wreg_reg != 5'd0 && mw_wreg_reg == x_srcb) ? data_writeReg :
               dx_b_reg;

  assign x_imm  = {{15{dx_insn_reg[16]}}, dx_insn_reg[16:0]};
  assign x_sum  = x_a + x_b;
  assign x_diff = x_a - x_b;
  assign x_addr = x_a + x_imm;

  always_comb begin
    x_result = '0;
    x_we     = 1'b0;
    x_wreg   = x_rd;
    x_ovf    = 1'b0;
    x_code   = '0;
    case (x_op)
      OP_R: begin
        case (x_aluop)
          ALU_ADD: begin
            x_result = x_sum;
            x_we     = 1'b1;
            x_ovf    = (x_a[31] == x_b[31]) && (x_sum[31] != x_a[31]);
            x_code   = 32'd1;
          end
          ALU_SUB: begin
            x_result = x_diff;
            x_we     = 1'b1;
            x_ovf    = (x_a[31] != x_b[31]) && (x_diff[31] != x_a[31]);
            x_code   = 32'd3;
          end
          ALU_AND: begin x_result = x_a & x_b; x_we = 1'b1; end
          ALU_OR:  begin x_result = x_a | x_b; x_we = 1'b1; end
          ALU_SLL: begin x_result = x_a << x_shamt; x_we = 1'b1; end
          ALU_SRA: begin x_result = $unsigned($signed(x_a) >>> x_shamt); x_we = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        x_result = x_addr;
        x_we     = 1'b1;
        x_ovf    = (x_a[31] == x_imm[31]) && (x_addr[31] != x_a[31]);
        x_code   = 32'd2;
      end
      OP_SW:   x_result = x_addr;
      OP_LW:   begin x_result = x_addr; x_we = 1'b1; end
      default: ;
    endcase
    // An overflowing op is redirected to the status register r30.
    if (x_ovf) begin
      x_wreg   = 5'd30;
      x_result = x_code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xm_we_reg   <= 1'b0;
      xm_sw_reg   <= 1'b0;
      xm_lw_reg   <= 1'b0;
      xm_wreg_reg <= '0;
      xm_rd_reg   <= '0;
      xm_val_reg  <= '0;
      xm_b_reg    <= '0;
    end else begin
      xm_we_reg   <= x_we;
      xm_sw_reg   <= (x_op == OP_SW);
      xm_lw_reg   <= (x_op == OP_LW);
      xm_wreg_reg <= x_wreg;
      xm_rd_reg   <= x_rd;
      xm_val_reg  <= x_result;
      xm_b_reg    <= x_b;
    end
  end

  // ---------------------------------------------------------------- memory / writeback
  assign address_dmem = xm_val_reg[11:0];
  assign wren_dmem    = xm_sw_reg;
  assign d_dmem       = (mw_we_reg && mw_wreg_reg != 5'd0 && mw_wreg_reg == xm_rd_reg) ?
                        data_writeReg : xm_b_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mw_we_reg   <= 1'b0;
      mw_lw_reg   <= 1'b0;
      mw_wreg_reg <= '0;
      mw_val_reg  <= '0;
    end else begin
      mw_we_reg   <= xm_we_reg;
      mw_lw_reg   <= xm_lw_reg;
      mw_wreg_reg <= xm_wreg_reg;
      mw_val_reg  <= xm_val_reg;
    end
  end

  assign ctrl_writeEnable = mw_we_reg;
  assign ctrl_writeReg    = mw_wreg_reg;
  assign data_writeReg    = mw_lw_reg ? q_dmem_reg : mw_val_reg;

  logic unused_bits;
  assign unused_bits = ^dx_insn_reg[1:0];

endmodule

// File: tb/tb_skeleton_ta_top.sv
// Directed-program bench for skeleton_ta_top: loads short programs into the ROM,
// runs them and compares architectural results against hand-computed values.
module tb_skeleton_ta_top;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_imem, address_dmem;
  logic [31:0] q_imem, d_dmem, q_dmem;
  logic        wren_dmem, ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;

  always #5 clock = ~clock;

  skeleton_ta_top #(.IMEM_FILE(""), .MEM_DEPTH(4096)) dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .address_dmem(address_dmem), .d_dmem(d_dmem), .wren_dmem(wren_dmem), .q_dmem(q_dmem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] prog [$];
  int          stall_cnt, store_cnt;
  logic [11:0] store_addr;
  logic [31:0] store_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] aluop, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] shamt);
    return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, rd, rs, v[16:0]};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs, input int imm);
    return itype(5'b00101, rd, rs, imm);
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.rf_regs[i];
  endfunction

  // Hold reset, load the queued program (rest of the window as nops), release.
  task automatic start_prog();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.imem_rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
    prog.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Run n cycles, counting repeated fetch addresses (stalls) and observing stores.
  task automatic run(input int n);
    logic [11:0] prev;
    stall_cnt = 0;
    store_cnt = 0;
    prev = address_imem;
    repeat (n) begin
      @(negedge clock);
      if (address_imem == prev) stall_cnt++;
      prev = address_imem;
      if (wren_dmem) begin
        store_cnt++;
        store_addr = address_dmem;
        store_data = d_dmem;
      end
    end
  endtask

  initial begin
    int nonzero;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("reset_pc", {20'd0, address_imem}, 32'd0);
    check_eq("reset_q_imem", q_imem, 32'd0);
    check_eq("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check_eq("reset_wren", {31'd0, wren_dmem}, 32'd0);

    // MX/WX bypass, no stall
    prog.push_back(addi(1, 0, 3));
    prog.push_back(addi(2, 0, 3));
    prog.push_back(rtype(5'd0, 3, 1, 2, 0));
    start_prog();
    run(20);
    check_eq("t1_r1", rf(1), 32'd3);
    check_eq("t1_r2", rf(2), 32'd3);
    check_eq("t1_r3", rf(3), 32'd6);
    check_eq("t1_stalls", stall_cnt, 32'd0);

    // Immediate sign extension and r0 hardwired
    prog.push_back(addi(7, 0, -99));
    prog.push_back(addi(8, 0, 666));
    prog.push_back(addi(0, 0, 5));
    start_prog();
    run(20);
    check_eq("t2_r7", rf(7), 32'hFFFFFF9D);
    check_eq("t2_r8", rf(8), 32'd666);
    check_eq("t2_r0", rf(0), 32'd0);

    // Store with forwarded data, load back, address wrap at 12 bits
    prog.push_back(addi(4, 0, 999));
    prog.push_back(itype(5'b00111, 4, 0, 5));
    prog.push_back(itype(5'b01000, 9, 0, 5));
    prog.push_back(itype(5'b01000, 10, 0, 4101));
    start_prog();
    run(24);
    check_eq("t3_store_count", store_cnt, 32'd1);
    check_eq("t3_store_addr", {20'd0, store_addr}, 32'd5);
    check_eq("t3_store_data", store_data, 32'd999);
    check_eq("t3_r9", rf(9), 32'd999);
    check_eq("t3_r10_wrap", rf(10), 32'd999);

    // Load-use stall; data RAM survives reset
    prog.push_back(itype(5'b01000, 5, 0, 5));
    prog.push_back(rtype(5'd0, 6, 5, 5, 0));
    start_prog();
    run(24);
    check_eq("t4_stalls", stall_cnt, 32'd1);
    check_eq("t4_r5", rf(5), 32'd999);
    check_eq("t4_r6", rf(6), 32'd1998);

    // Logic, subtract and shift operations including shift boundaries
    prog.push_back(addi(1, 0, 12));
    prog.push_back(addi(2, 0, 10));
    prog.push_back(rtype(5'd2, 3, 1, 2, 0));
    prog.push_back(rtype(5'd3, 4, 1, 2, 0));
    prog.push_back(rtype(5'd1, 5, 1, 2, 0));
    prog.push_back(rtype(5'd1, 6, 2, 1, 0));
    prog.push_back(rtype(5'd4, 7, 1, 0, 4));
    prog.push_back(addi(8, 0, -16));
    prog.push_back(rtype(5'd5, 9, 8, 0, 2));
    prog.push_back(rtype(5'd4, 10, 1, 0, 0));
    prog.push_back(rtype(5'd5, 11, 8, 0, 31));
    prog.push_back(addi(13, 0, 1));
    prog.push_back(rtype(5'd4, 12, 13, 0, 31));
    start_prog();
    run(30);
    check_eq("t5_and", rf(3), 32'd8);
    check_eq("t5_or", rf(4), 32'd14);
    check_eq("t5_sub", rf(5), 32'd2);
    check_eq("t5_sub_neg", rf(6), 32'hFFFFFFFE);
    check_eq("t5_sll4", rf(7), 32'd192);
    check_eq("t5_sra2", rf(9), 32'hFFFFFFFC);
    check_eq("t5_sll0", rf(10), 32'd12);
    check_eq("t5_sra31", rf(11), 32'hFFFFFFFF);
    check_eq("t5_sll31", rf(12), 32'h80000000);
    check_eq("t5_stalls", stall_cnt, 32'd0);

    // add overflow
    prog.push_back(addi(1, 0, 32'hFFFF));
    prog.push_back(rtype(5'd4, 1, 1, 0, 15));
    prog.push_back(addi(1, 1, 32'h7FFF));
    prog.push_back(rtype(5'd0, 2, 1, 1, 0));
    start_prog();
    run(24);
    check_eq("t6_r1", rf(1), 32'h7FFFFFFF);
    check_eq("t6_r2_kept", rf(2), 32'd0);
    check_eq("t6_r30_add", rf(30), 32'd1);

    // addi overflow
    prog.push_back(addi(1, 0, 32'hFFFF));
    prog.push_back(rtype(5'd4, 1, 1, 0, 15));
    prog.push_back(addi(1, 1, 32'h7FFF));
    prog.push_back(addi(3, 1, 1));
    start_prog();
    run(24);
    check_eq("t7_r3_kept", rf(3), 32'd0);
    check_eq("t7_r30_addi", rf(30), 32'd2);

    // sub overflow, and a non-overflowing wrap through zero
    prog.push_back(addi(7, 0, -1));
    prog.push_back(addi(8, 7, 2));
    prog.push_back(addi(5, 0, 1));
    prog.push_back(rtype(5'd4, 5, 5, 0, 31));
    prog.push_back(rtype(5'd1, 4, 0, 5, 0));
    start_prog();
    run(24);
    check_eq("t8_wrap", rf(8), 32'd1);
    check_eq("t8_r4_kept", rf(4), 32'd0);
    check_eq("t8_r30_sub", rf(30), 32'd3);

    // Reset asserted mid-run
    for (int i = 1; i <= 5; i++) prog.push_back(addi(i[4:0], 0, i));
    start_prog();
    run(6);
    check_eq("t9_pre_we", {31'd0, ctrl_writeEnable}, 32'd1);
    check_eq("t9_pre_r1", rf(1), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t9_rst_pc", {20'd0, address_imem}, 32'd0);
    check_eq("t9_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check_eq("t9_rst_q_imem", q_imem, 32'd0);
    nonzero = 0;
    for (int i = 1; i < 32; i++) if (rf(i) != 32'd0) nonzero++;
    check_eq("t9_rst_regs_nonzero", nonzero, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run(20);
    check_eq("t9_rerun_r5", rf(5), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
